// File: rtl/rapid_mem_stage.sv
// MEM stage of the rapid pipeline: pass-through of ALU results, and loads/stores
// over a single-port data-cache req/ack interface with load alignment and extension.
module rapid_mem_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_mem,
    input  logic            ex_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_pc,
    output logic            cache_req,
    output logic            cache_rw,
    output logic [1:0]      cache_op,
    output logic [XLEN-1:0] cache_addr,
    output logic [XLEN-1:0] cache_wdata,
    output logic [3:0]      cache_be,
    input  logic            cache_ack,
    input  logic [XLEN-1:0] cache_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] wb_pc,
    output logic            mem_fault,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        MEM_WAIT  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MEM_state_t;

    MEM_state_t state, next_state;

    logic            accept;
    logic            illegal_f3;
    logic            misaligned;
    logic            is_fault;
    logic [1:0]      dec_op;
    logic [3:0]      be_base;
    logic [3:0]      dec_be;
    logic [XLEN-1:0] dec_wdata;
    logic [2:0]      ld_funct3;
    logic [XLEN-1:0] rdata_shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_data;

    // Handshake: EX holds its fields while ex_valid is high; a transfer happens on the
    // rising edge where ex_valid && ex_ready. ex_ready is high only while idle and out of reset.
    assign ex_ready  = (state == MEM_WAIT) && !reset;
    assign accept    = ex_valid && ex_ready;
    assign dbg_state = state;

    always_comb begin
        illegal_f3 = 1'b0;
        misaligned = 1'b0;
        dec_op     = 2'd0;
        be_base    = 4'b0000;
        if (ex_store) illegal_f3 = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
        else          illegal_f3 = (ex_funct3[1:0] == 2'b11) || (ex_funct3 == 3'b110);
        case (ex_funct3[1:0])
            2'b00: begin dec_op = 2'd1; be_base = 4'b0001; end
            2'b01: begin dec_op = 2'd2; be_base = 4'b0011; misaligned = ex_alu_result[0]; end
            2'b10: begin dec_op = 2'd3; be_base = 4'b1111; misaligned = (ex_alu_result[1:0] != 2'b00); end
            default: ;
        endcase
        is_fault  = ex_mem && (illegal_f3 || misaligned);
        dec_be    = be_base << ex_alu_result[1:0];
        dec_wdata = ex_store_data << {ex_alu_result[1:0], 3'b000};
    end

    // Extraction uses the held request address and funct3 captured at acceptance.
    always_comb begin
        rdata_shifted = cache_rdata >> {cache_addr[1:0], 3'b000};
        byte_v        = rdata_shifted[7:0];
        half_v        = cache_addr[1] ? cache_rdata[31:16] : cache_rdata[15:0];
        case (ld_funct3)
            3'b000:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_v};
            default: load_data = cache_rdata;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            MEM_WAIT: begin
                if (accept && ex_mem && !is_fault)
                    next_state = ex_store ? MEM_WRITE : MEM_READ;
            end
            MEM_READ, MEM_WRITE: begin
                if (cache_ack) next_state = MEM_WAIT;
            end
            default: next_state = MEM_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MEM_WAIT;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_req   <= 1'b0;
            cache_rw    <= 1'b0;
            cache_op    <= 2'd0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_be    <= 4'b0000;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= '0;
            wb_pc       <= RESET_VECTOR;
            mem_fault   <= 1'b0;
            ld_funct3   <= 3'b000;
        end else begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                MEM_WAIT: begin
                    if (accept) begin
                        wb_rd <= ex_rd;
                        wb_pc <= ex_pc;
                        if (!ex_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (ex_rd != 5'd0);
                            wb_data  <= ex_alu_result;
                        end else if (is_fault) begin
                            wb_valid  <= 1'b1;
                            mem_fault <= 1'b1;
                            wb_data   <= '0;
                        end else begin
                            cache_req   <= 1'b1;
                            cache_rw    <= ex_store;
                            cache_op    <= dec_op;
                            cache_addr  <= ex_alu_result;
                            cache_wdata <= ex_store ? dec_wdata : '0;
                            cache_be    <= ex_store ? dec_be : 4'b0000;
                            ld_funct3   <= ex_funct3;
                        end
                    end
                end
                MEM_READ, MEM_WRITE: begin
                    if (cache_ack) begin
                        cache_req <= 1'b0;
                        cache_rw  <= 1'b0;
                        cache_op  <= 2'd0;
                        cache_be  <= 4'b0000;
                        wb_valid  <= 1'b1;
                        wb_we     <= (state == MEM_READ) && (wb_rd != 5'd0);
                        wb_data   <= (state == MEM_READ) ? load_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rapid_mem_stage.md
Name: rapid_mem_stage

Overview:
- Memory (MEM) stage of the rapid pipeline. Sits between the execute stage (EX) and writeback (WB).
- Accepts one EX result at a time and performs loads and stores through a single-port data-cache request/acknowledge interface.
- Load data is aligned and sign- or zero-extended before it goes to WB.
- Non-memory results pass through to WB with one cycle of latency.

Parameters:
- XLEN, 32, data and address width.
- RESET_VECTOR, 0, value driven on wb_pc after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage can accept; a transfer occurs when ex_valid && ex_ready.
- ex_mem  in  1  instruction is a load or store.
- ex_store  in  1  1 = store, 0 = load (meaningful only when ex_mem = 1).
- ex_funct3  in  3  fcs_opcode: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- ex_alu_result  in  XLEN  effective address, or the ALU result for non-memory instructions.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_rd  in  5  destination register.
- ex_pc  in  XLEN  instruction PC.
- cache_req  out  1  request strobe.
- cache_rw  out  1  0 = CACHE_READ, 1 = CACHE_WRITE.
- cache_op  out  2  0 = CACHE_NOP, 1 = QUARTER_WORD, 2 = HALF_WORD, 3 = WORD.
- cache_addr  out  XLEN  byte address.
- cache_wdata  out  XLEN  store data, lane-shifted.
- cache_be  out  4  byte enables.
- cache_ack  in  1  one-cycle completion pulse.
- cache_rdata  in  XLEN  word containing the addressed byte; valid with cache_ack.
- wb_valid  out  1  one-cycle result pulse.
- wb_we  out  1  register write enable.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  result.
- wb_pc  out  XLEN  PC of the result.
- mem_fault  out  1  misaligned access or illegal funct3; pulses together with wb_valid.

Behaviour:
- Reset: state = MEM_WAIT. cache_req, cache_rw, cache_op, cache_be, wb_valid, wb_we and mem_fault are 0. cache_addr, cache_wdata, wb_data and wb_rd are 0. wb_pc = RESET_VECTOR.
- A reset that arrives mid-transaction abandons it. Any cache_ack arriving after reset is ignored.
- ex_ready = (state == MEM_WAIT) && !reset.
- State machine uses MEM_state_t: MEM_WAIT, MEM_READ, MEM_WRITE.
- MEM_WAIT, transfer with ex_mem = 0:
  - Next cycle: wb_valid = 1, wb_we = (ex_rd != 0), wb_data = ex_alu_result.
  - State stays MEM_WAIT.
- MEM_WAIT, transfer of a legal, aligned load:
  - Next cycle: cache_req = 1, cache_rw = 0, cache_op from funct3 (000/100 -> 1, 001/101 -> 2, 010 -> 3).
  - cache_addr = ex_alu_result. State goes to MEM_READ.
- MEM_WAIT, transfer of a legal, aligned store:
  - cache_rw = 1; state goes to MEM_WRITE.
  - cache_wdata = ex_store_data << (8*addr[1:0]).
  - cache_be = 0001/0011/1111 shifted left by addr[1:0].
- Loads set cache_be = 0000.
- MEM_READ and MEM_WRITE:
  - Hold cache_req and all cache outputs stable until cache_ack.
  - In the cycle after cache_ack: cache_req = 0 and state returns to MEM_WAIT.
  - Also in that cycle: wb_valid = 1.
  - For a load, wb_we = (rd != 0) and wb_data is extracted from cache_rdata.
  - For a store, wb_we = 0 and wb_data = 0.
- A cache_ack seen in MEM_WAIT is ignored.
- Load extraction, with byte lane = addr[1:0] and half lane = addr[1]:
  - LB sign-extends bit 7 of the byte; LBU zero-extends.
  - LH sign-extends bit 15 of the half; LHU zero-extends.
  - LW passes the word unchanged.
- Faults:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] != 0, is a fault.
  - An illegal funct3 is a fault: loads 011/110/111; stores anything other than 000/001/010.
  - On a fault: no cache request; the next cycle pulses wb_valid = 1, mem_fault = 1, wb_we = 0. State stays MEM_WAIT.
- Throughput:
  - Pass-through and faulting ops: one per cycle.
  - Memory ops: minimum 3 cycles from acceptance to the next acceptance with a zero-wait cache (request cycle, ack, WB cycle).
- wb_rd and wb_pc are registered at acceptance and remain stable until the next acceptance.

Test Plan:
- Reset: assert reset for 2 cycles mid-MEM_READ -> cache_req = 0, wb_valid = 0, ex_ready = 1 on the first post-reset cycle; a late cache_ack produces no wb_valid.
- Pass-through: ex_mem = 0, ex_alu_result = 0x1234, rd = 5 -> next cycle wb_valid = 1, wb_we = 1, wb_data = 0x1234. Repeat with rd = 0 -> wb_we = 0.
- Load extraction: cache_rdata = 0x80FF7F01.
  - LB @0x103 -> 0xFFFFFF80.
  - LBU @0x103 -> 0x00000080.
  - LH @0x102 -> 0xFFFF80FF.
  - LHU @0x100 -> 0x00007F01.
  - LW @0x100 -> 0x80FF7F01.
  - Verify cache_op is 1 or 2 or 3 respectively.
- Store lanes: SB data = 0xAABBCCDD @0x201 -> cache_wdata = 0xBBCCDD00, cache_be = 0010. SH @0x202 -> cache_wdata = 0xCCDD0000, be = 1100. SW @0x200 -> be = 1111; wb_we = 0.
- Wait states: cache_ack delayed 5 cycles -> cache_req and cache_addr stable throughout, ex_ready = 0; exactly one wb_valid pulse after the ack.
- Faults: LW @0x102, LH @0x101, funct3 = 011 load, SB with funct3 = 100 -> no cache_req; next cycle mem_fault = 1, wb_valid = 1, wb_we = 0; a back-to-back pass-through op is accepted the following cycle.
